// File: rtl/tls_pkg.sv
// Shared opcodes, command field layout and duration rules for the traffic-light command path.
// Also holds the issue FSM state type and a helper that unpacks a raw 14-bit command word.
package tls_pkg;

  localparam int CMD_W = 14;
  localparam int DUR_W = 4;
  localparam int OP_W  = 2;
  localparam int R_MIN = 2;

  localparam int OP_LSB = 12;
  localparam int G_LSB  = 8;
  localparam int Y_LSB  = 4;
  localparam int R_LSB  = 0;

  localparam logic [OP_W-1:0] OP_SET      = 2'b00;
  localparam logic [OP_W-1:0] OP_STOP_ON  = 2'b01;
  localparam logic [OP_W-1:0] OP_STOP_OFF = 2'b10;
  localparam logic [OP_W-1:0] OP_JUMP     = 2'b11;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [DUR_W-1:0] g;
    logic [DUR_W-1:0] y;
    logic [DUR_W-1:0] r;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } state_e;

  function automatic cmd_t to_cmd(logic [CMD_W-1:0] raw);
    cmd_t c;
    c.op = raw[OP_LSB +: OP_W];
    c.g  = raw[G_LSB +: DUR_W];
    c.y  = raw[Y_LSB +: DUR_W];
    c.r  = raw[R_LSB +: DUR_W];
    return c;
  endfunction

  // A SET with a zero phase or a too-short red would stall or glitch the controller.
  function automatic logic set_ok(cmd_t c);
    return (c.g != '0) && (c.y != '0) && (c.r >= DUR_W'(R_MIN));
  endfunction

endpackage

// File: rtl/tls_cmd_sequencer_if.sv
// Host command stream plus the control bundle driven into the traffic-light controller.
// The sequencer is the slave of the command stream and the source of the control outputs.
interface tls_cmd_sequencer_if #(
  parameter int DEPTH = 4
);
  import tls_pkg::*;

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [CMD_W-1:0]         cmd_data;
  logic                     Set;
  logic                     Stop;
  logic                     Jump;
  logic [DUR_W-1:0]         Gin;
  logic [DUR_W-1:0]         Yin;
  logic [DUR_W-1:0]         Rin;
  logic                     err;
  logic [$clog2(DEPTH):0]   fifo_level;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, Set, Stop, Jump, Gin, Yin, Rin, err, fifo_level
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, Set, Stop, Jump, Gin, Yin, Rin, err, fifo_level
  );

endinterface

// File: rtl/tls_cmd_fifo.sv
// Synchronous DEPTH x W command FIFO; push lands on the clock edge, head data is combinational.
// full_o is registered from the next level so callers never see a path from push back to ready.
module tls_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           pop_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             full_q;

  always_comb begin
    level_d = level_q;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;

endmodule

// File: rtl/tls_cmd_sequencer.sv
// Turns buffered host commands into spaced Set/Jump pulses, a Stop level and held G/Y/R durations.
// Pulse appears two edges after accept into an idle block; MIN_GAP (>=1) quiet cycles follow each pulse.
module tls_cmd_sequencer
  import tls_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MIN_GAP = 2
) (
  input  logic               clk,
  input  logic               reset,
  tls_cmd_sequencer_if.slave bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CMD_W-1:0] head;
  logic [LVL_W-1:0] level;

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             set_q, set_d;
  logic             jump_q, jump_d;
  logic             stop_q, stop_d;
  logic             err_q, err_d;
  logic [DUR_W-1:0] g_q, g_d;
  logic [DUR_W-1:0] y_q, y_d;
  logic [DUR_W-1:0] r_q, r_d;

  assign push = bus.cmd_valid & ~full;

  tls_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (push),
    .push_dat_i (bus.cmd_data),
    .pop_i      (pop),
    .pop_dat_o  (head),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    set_d   = 1'b0;
    jump_d  = 1'b0;
    err_d   = 1'b0;
    stop_d  = stop_q;
    g_d     = g_q;
    y_d     = y_q;
    r_d     = r_q;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cmd_d   = to_cmd(head);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_IDLE;
        gap_d   = GAP_W'(MIN_GAP - 1);
        // Only one opcode issues per visit, so Set and Jump can never coincide.
        case (cmd_q.op)
          OP_SET: begin
            if (set_ok(cmd_q)) begin
              g_d     = cmd_q.g;
              y_d     = cmd_q.y;
              r_d     = cmd_q.r;
              set_d   = 1'b1;
              state_d = ST_GAP;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_JUMP: begin
            jump_d  = 1'b1;
            state_d = ST_GAP;
          end
          OP_STOP_ON:  stop_d = 1'b1;
          OP_STOP_OFF: stop_d = 1'b0;
          default:     stop_d = stop_q;
        endcase
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      gap_q   <= '0;
      set_q   <= 1'b0;
      jump_q  <= 1'b0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
      g_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      gap_q   <= gap_d;
      set_q   <= set_d;
      jump_q  <= jump_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
      g_q     <= g_d;
      y_q     <= y_d;
      r_q     <= r_d;
    end
  end

  assign bus.cmd_ready  = ~full;
  assign bus.Set        = set_q;
  assign bus.Jump       = jump_q;
  assign bus.Stop       = stop_q;
  assign bus.err        = err_q;
  assign bus.Gin        = g_q;
  assign bus.Yin        = y_q;
  assign bus.Rin        = r_q;
  assign bus.fifo_level = level;

endmodule
